// File: rtl/mem_responder.sv
// Word-organised data memory responder with valid/ready request/response handshake and fixed wait states.
// Optional misaligned-access error reporting is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic            lat_wr;
  logic [AW-1:0]   lat_idx;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;
  logic            lat_misalign;
  logic            misalign_in;
  logic            accept, capture, handshake, commit;
  logic            unused_bits;
  logic [31:0]     mem [DEPTH_WORDS];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_in = |req_addr[1:0];
  assign unused_bits = ^req_addr[31:AW+2];
`else
  assign misalign_in = 1'b0;
  assign unused_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  // First cycle in RESP is the access cycle; resp_valid rises at its closing edge.
  assign capture   = (state == RESP) && !resp_valid;
  assign handshake = resp_valid && resp_ready;
  assign commit    = capture && lat_wr && !lat_misalign;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = (LATENCY > 0) ? WAIT : RESP;
      WAIT: if (cnt <= 4'd1) state_next = RESP;
      RESP: if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_wr       <= req_wr;
      lat_idx      <= req_addr[AW+1:2];
      lat_wdata    <= req_wdata;
      lat_be       <= req_be;
      lat_misalign <= misalign_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      err        <= 1'b0;
    end else begin
      if (accept)              cnt <= 4'(LATENCY);
      else if (state == WAIT)  cnt <= cnt - 4'd1;
      if (capture) begin
        resp_valid <= 1'b1;
        resp_rdata <= (lat_wr || lat_misalign) ? '0 : mem[lat_idx];
        err        <= lat_misalign;
      end else if (handshake) begin
        resp_valid <= 1'b0;
        resp_rdata <= '0;
        err        <= 1'b0;
      end
    end
  end

  // Storage has no reset; the rst term discards a write whose commit edge coincides with reset.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule
